// File: rtl/qa_bit_serializer_if.sv
// Word-in / slice-out bundle for qa_bit_serializer: producer-side word strobe,
// readback-side serial stream plus status.
interface qa_bit_serializer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         in_data;
    logic                     in_nd;
    logic [WIDTH-1:0]         out_data;
    logic                     out_nd;
    logic                     out_last;
    logic                     error;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output in_data, in_nd,
        input  out_data, out_nd, out_last, error, fifo_count
    );

    modport slave (
        input  in_data, in_nd,
        output out_data, out_nd, out_last, error, fifo_count
    );
endinterface

// File: rtl/qa_bit_serializer.sv
// Buffers WIDTH-bit words in a small FIFO and emits them MSB-first as CHUNK-bit
// slices (position/value pairs or values only); overflow latches a sticky error.
module qa_bit_serializer #(
    parameter int          WIDTH     = 32,
    parameter int          CHUNK     = 1,
    parameter int          DEPTH     = 4,
    parameter int          MODE      = 0,
    parameter logic [31:0] ERRORCODE = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    qa_bit_serializer_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    FULL_C     = CW'(DEPTH);
    localparam logic [IW-1:0]    IDX_TOP_C  = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] ERR_WORD_C = WIDTH'(ERRORCODE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_VAL  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] word_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_nd_r;
    logic             out_last_r;
    logic             error_r;

    logic fifo_empty_s;
    logic pop_s;
    logic accept_s;
    logic overflow_s;
    logic push_s;

    function automatic logic [CHUNK-1:0] slice_f(input logic [WIDTH-1:0] w,
                                                 input logic [IW-1:0]    i);
        logic [WIDTH-1:0] sh;
        sh = w >> (int'(i) * CHUNK);
        return sh[CHUNK-1:0];
    endfunction

    // Pop whenever the serializer is ready for a new word; a pop frees a slot
    // for a same-edge write, so only a write to a full FIFO without pop overflows.
    always_comb begin
        fifo_empty_s = (count_r == {CW{1'b0}});
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_VAL:  pop_s = (idx_r == {IW{1'b0}}) && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
        accept_s   = bus.in_nd && (state_r != ST_ERR);
        overflow_s = accept_s && (count_r == FULL_C) && !pop_s;
        push_s     = accept_s && !overflow_s;
    end

    // FIFO storage, wrapping pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.in_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Serializer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            word_r     <= {WIDTH{1'b0}};
            idx_r      <= {IW{1'b0}};
            out_data_r <= {WIDTH{1'b0}};
            out_nd_r   <= 1'b0;
            out_last_r <= 1'b0;
            error_r    <= 1'b0;
        end else if (overflow_s) begin
            state_r    <= ST_ERR;
            out_data_r <= ERR_WORD_C;
            out_nd_r   <= 1'b1;
            out_last_r <= 1'b0;
            error_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_last_r <= 1'b0;
                    if (pop_s) begin
                        word_r  <= mem_r[rd_ptr_r];
                        idx_r   <= IDX_TOP_C;
                        state_r <= ST_VAL;
                        if (MODE == 0) begin
                            out_data_r <= WIDTH'(IDX_TOP_C);
                            out_nd_r   <= 1'b1;
                        end else begin
                            out_nd_r   <= 1'b0;
                        end
                    end else begin
                        out_nd_r <= 1'b0;
                    end
                end
                ST_POS: begin
                    out_data_r <= WIDTH'(idx_r);
                    out_nd_r   <= 1'b1;
                    out_last_r <= 1'b0;
                    state_r    <= ST_VAL;
                end
                ST_VAL: begin
                    out_data_r <= WIDTH'(slice_f(word_r, idx_r));
                    out_nd_r   <= 1'b1;
                    if (idx_r != {IW{1'b0}}) begin
                        out_last_r <= 1'b0;
                        idx_r      <= idx_r - IW'(1);
                        state_r    <= (MODE == 0) ? ST_POS : ST_VAL;
                    end else begin
                        out_last_r <= 1'b1;
                        // Chain straight into the next word so streams have no gaps.
                        if (pop_s) begin
                            word_r  <= mem_r[rd_ptr_r];
                            idx_r   <= IDX_TOP_C;
                            state_r <= (MODE == 0) ? ST_POS : ST_VAL;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    out_data_r <= ERR_WORD_C;
                    out_nd_r   <= 1'b1;
                    out_last_r <= 1'b0;
                    error_r    <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    out_nd_r   <= 1'b0;
                    out_last_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_data   = out_data_r;
    assign bus.out_nd     = out_nd_r;
    assign bus.out_last   = out_last_r;
    assign bus.error      = error_r;
    assign bus.fifo_count = count_r;
endmodule
